mac_burst_arbiter: RTL and testbench

Round-robin scheduler that shares one 4-bit multiply / 8-bit accumulate datapath among `NREQ` requesters. Each requester streams a burst of operand pairs over a valid/ready handshake. The block accumulates the products of that burst and returns one 8-bit result, tagged with the requester ID and an overflow flag. It sits between the operand producers and the result consumer, in front of the MAC datapath, and owns the accumulator's clear/accumulate sequencing.

---
 rtl/mac_burst_arbiter.sv | 78 +++++++
 tb/tb_mac_burst_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_burst_arbiter.sv
// mac_burst_arbiter: round-robin burst scheduler in front of a shared 4x4 multiply / 8-bit accumulate datapath.
// One burst per grant; the result is held until the consumer accepts it, then IDLE re-arbitrates.
module mac_burst_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data,
  output logic              res_ovf,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q;
  logic [IDW-1:0] ptr_q, g_q, pick;
  logic [7:0]     acc_q, prod;
  logic           ovf_q, any_valid, fire;
  logic [3:0]     a_g, b_g;
  logic [8:0]     sum;
  // Scan downward so the nearest valid index after ptr_q is the last one written.
  always_comb begin
    pick = '0;
    any_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        pick = IDW'((int'(ptr_q) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end
  assign a_g  = req_a[{g_q, 2'b00} +: 4];
  assign b_g  = req_b[{g_q, 2'b00} +: 4];
  assign prod = {4'b0, a_g} * {4'b0, b_g};
  assign sum  = {1'b0, acc_q} + {1'b0, prod};
  assign fire = (state_q == RUN) && req_valid[g_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      g_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (any_valid) begin
          g_q     <= pick;
          acc_q   <= '0;
          ovf_q   <= 1'b0;
          state_q <= RUN;
        end
        RUN: if (fire) begin
          acc_q <= sum[7:0];
          ovf_q <= ovf_q | sum[8];
          if (req_last[g_q]) state_q <= DONE;
        end
        DONE: if (res_ready) begin
          ptr_q   <= g_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready = (state_q == RUN) ? ({{(NREQ-1){1'b0}}, 1'b1} << g_q) : '0;
  assign res_valid = state_q == DONE;
  assign res_data  = acc_q;
  assign res_ovf   = ovf_q;
  assign res_id    = g_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mac_burst_arbiter.sv
// tb_mac_burst_arbiter: table-driven single bursts, hand-written round-robin/reset sequences,
// and randomized multi-requester traffic against a round-robin/sum reference model.
module tb_mac_burst_arbiter;
  localparam int N = 4;
  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [4*N-1:0] req_a = '0, req_b = '0;
  logic           res_valid, res_ready = 1'b0, res_ovf, busy;
  logic [7:0]     res_data;
  logic [1:0]     res_id;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mac_burst_arbiter #(.NREQ(N), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf), .res_id(res_id), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " req_ready"}, int'(req_ready), 0);
    chk({tag, " res_valid"}, int'(res_valid), 0);
    chk({tag, " res_data"}, int'(res_data), 0);
    chk({tag, " res_ovf"}, int'(res_ovf), 0);
    chk({tag, " res_id"}, int'(res_id), 0);
    chk({tag, " busy"}, int'(busy), 0);
  endtask

  typedef struct {
    int id; int n; int gap; int hold;
    logic [3:0][3:0] a; logic [3:0][3:0] b;
    int exp_data; int exp_ovf;
  } vec_t;

  task automatic burst(input vec_t v, input string tag);
    int beat = 0, wait_c = 0, cyc = 0;
    while (beat < v.n && cyc < 200) begin
      @(negedge clk); cyc++;
      if (wait_c > 0) begin
        req_valid[v.id] = 1'b0;
        wait_c--;
      end else begin
        req_valid[v.id] = 1'b1;
        req_a[4*v.id +: 4] = v.a[beat];
        req_b[4*v.id +: 4] = v.b[beat];
        req_last[v.id] = (beat == v.n - 1);
        if (req_ready[v.id]) begin
          beat++;
          wait_c = v.gap;
        end
      end
    end
    @(negedge clk);
    req_valid = '0;
    req_last = '0;
    chk({tag, " latency"}, cyc, 1 + v.n + (v.n - 1) * v.gap);
    for (int h = 0; h <= v.hold; h++) begin
      if (h > 0) @(negedge clk);
      chk({tag, " res_valid"}, int'(res_valid), 1);
      chk({tag, " res_data"}, int'(res_data), v.exp_data);
      chk({tag, " res_ovf"}, int'(res_ovf), v.exp_ovf);
      chk({tag, " res_id"}, int'(res_id), v.id);
      chk({tag, " no grant in DONE"}, int'(req_ready), 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, " res_valid drop"}, int'(res_valid), 0);
    chk({tag, " idle"}, int'(busy), 0);
  endtask

  task automatic rr(input logic [N-1:0] mask, input logic [4*N-1:0] a, input logic [4*N-1:0] b,
                    input int cnt, input logic [4:0][1:0] eid, input logic [4:0][7:0] edata,
                    input string tag);
    int got = 0, cyc = 0;
    @(negedge clk);
    req_valid = mask;
    req_last = '1;
    req_a = a;
    req_b = b;
    res_ready = 1'b1;
    while (got < cnt && cyc < 100) begin
      @(negedge clk); cyc++;
      if (res_valid) begin
        chk($sformatf("%s id[%0d]", tag, got), int'(res_id), int'(eid[got]));
        chk($sformatf("%s data[%0d]", tag, got), int'(res_data), int'(edata[got]));
        got++;
      end
    end
    if (got < cnt) chk({tag, " timeout"}, got, cnt);
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, " idle"}, int'(busy), 0);
  endtask

  task automatic rand_test();
    int len[N], bi[N], esum[N], eovf[N];
    logic [3:0] ra[N][8], rb[N][8];
    bit pend[N];
    int cur = -1, ptr_m = N - 1, nres = 0, cyc = 0, e, s, p;
    logic [N-1:0] prev_v = '0;
    bit v;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; len[i] = 0; bi[i] = 0; esum[i] = 0; eovf[i] = 0;
    end
    while (nres < 40 && cyc < 5000) begin
      @(negedge clk); cyc++;
      if (cur < 0 && req_ready != 0) begin
        e = -1;
        for (int k = 1; k <= N; k++)
          if (e < 0 && prev_v[(ptr_m + k) % N]) e = (ptr_m + k) % N;
        chk("rand grant", int'(req_ready), e < 0 ? 0 : (1 << e));
        cur = e < 0 ? 0 : e;
      end
      res_ready = $urandom_range(0, 2) != 0;
      if (res_valid) begin
        chk("rand res_id", int'(res_id), cur);
        chk("rand res_data", int'(res_data), esum[cur]);
        chk("rand res_ovf", int'(res_ovf), eovf[cur]);
        if (res_ready) begin
          ptr_m = cur;
          pend[cur] = 1'b0;
          cur = -1;
          nres++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && i != cur && $urandom_range(0, 2) == 0) begin
          len[i] = $urandom_range(1, 6);
          bi[i] = 0; s = 0; eovf[i] = 0;
          for (int j = 0; j < len[i]; j++) begin
            ra[i][j] = 4'($urandom);
            rb[i][j] = 4'($urandom);
            p = int'(ra[i][j]) * int'(rb[i][j]);
            if (s % 256 + p >= 256) eovf[i] = 1;
            s += p;
          end
          esum[i] = s % 256;
          pend[i] = 1'b1;
        end
        v = pend[i] && bi[i] < len[i] && (i != cur || $urandom_range(0, 3) != 0);
        req_valid[i] = v;
        req_a[4*i +: 4] = ra[i][bi[i] % 8];
        req_b[4*i +: 4] = rb[i][bi[i] % 8];
        req_last[i] = (bi[i] == len[i] - 1);
        if (v && req_ready[i]) bi[i]++;
      end
      prev_v = req_valid;
    end
    if (nres < 40) chk("rand timeout", nres, 40);
    req_valid = '0;
    req_last = '0;
    res_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int beats;
    tbl[0] = '{0, 2, 0, 0, {4'd0, 4'd0, 4'd2, 4'd3}, {4'd0, 4'd0, 4'd7, 4'd5}, 29, 0};
    tbl[1] = '{2, 2, 0, 0, {4'd0, 4'd0, 4'd15, 4'd15}, {4'd0, 4'd0, 4'd15, 4'd15}, 194, 1};
    tbl[2] = '{1, 3, 2, 4, {4'd0, 4'd1, 4'd1, 4'd1}, {4'd0, 4'd1, 4'd1, 4'd1}, 3, 0};
    tbl[3] = '{3, 4, 0, 1, {4'd15, 4'd15, 4'd15, 4'd15}, {4'd15, 4'd15, 4'd15, 4'd15}, 132, 1};
    tbl[4] = '{0, 1, 0, 0, {4'd0, 4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0, 4'd9}, 0, 0};
    tbl[5] = '{3, 3, 0, 0, {4'd0, 4'd8, 4'd8, 4'd8}, {4'd0, 4'd8, 4'd8, 4'd8}, 192, 0};
    tbl[6] = '{2, 4, 1, 2, {4'd0, 4'd1, 4'd15, 4'd15}, {4'd0, 4'd1, 4'd1, 4'd15}, 241, 0};
    tbl[7] = '{1, 3, 0, 0, {4'd0, 4'd4, 4'd1, 4'd15}, {4'd0, 4'd4, 4'd15, 4'd15}, 0, 1};

    @(negedge clk); @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < 8; t++) burst(tbl[t], $sformatf("vec%0d", t));

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, {4'd1, 4'd1, 4'd1, 4'd1}, 5,
       {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, {8'd1, 8'd4, 8'd3, 8'd2, 8'd1}, "rr");

    @(negedge clk);
    req_valid[3] = 1'b1;
    req_a[15:12] = 4'd1;
    req_b[15:12] = 4'd1;
    req_last[3] = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      @(negedge clk);
      if (req_ready[3]) beats++;
    end
    @(negedge clk);
    chk("pre-reset partial sum", int'(res_data), 2);
    rst = 1'b1;
    #1;
    chk_zero("mid-burst reset");
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    rr(4'b1010, {4'd1, 4'd0, 4'd2, 4'd0}, {4'd1, 4'd0, 4'd3, 4'd0}, 2,
       {2'd0, 2'd0, 2'd0, 2'd3, 2'd1}, {8'd0, 8'd0, 8'd0, 8'd1, 8'd6}, "post-reset");

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rand_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
